// File: rtl/bus_initiator_pkg.sv
// Shared FSM state type and fixed bus constants for the single-initiator bus master.
package bus_initiator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_WDATA,
    ST_WEND,
    ST_WAIT_READ,
    ST_ERR_END,
    ST_RESPOND
  } state_t;

  // Only single-beat transfers are issued.
  localparam logic [7:0] BURST_SIZE = 8'd0;

  // States in which the initiator owns the bus and must keep requestOut asserted.
  function automatic logic holds_bus(input state_t s);
    return (s != ST_IDLE) && (s != ST_RESPOND);
  endfunction

endpackage

// File: rtl/bus_single_initiator_if.sv
// Command/response handshake plus wired-OR bus signals; master is the initiator's view, slave the environment's.
interface bus_single_initiator_if;
  logic        cmdValidIn;
  logic        cmdReadyOut;
  logic        cmdReadNWriteIn;
  logic [31:0] cmdAddressIn;
  logic [31:0] cmdWriteDataIn;
  logic [3:0]  cmdByteEnablesIn;

  logic        respValidOut;
  logic [31:0] respReadDataOut;
  logic        respErrorOut;

  logic        requestOut;
  logic        grantIn;

  logic        beginTransactionOut;
  logic        endTransactionOut;
  logic        readNWriteOut;
  logic        dataValidOut;
  logic        busyOut;
  logic [31:0] addressDataOut;
  logic [3:0]  byteEnablesOut;
  logic [7:0]  burstSizeOut;

  logic [31:0] addressDataIn;
  logic        endTransactionIn;
  logic        dataValidIn;
  logic        busErrorIn;

  modport master (
    input  cmdValidIn, cmdReadNWriteIn, cmdAddressIn, cmdWriteDataIn, cmdByteEnablesIn,
    output cmdReadyOut, respValidOut, respReadDataOut, respErrorOut,
    output requestOut,
    input  grantIn,
    output beginTransactionOut, endTransactionOut, readNWriteOut, dataValidOut, busyOut,
    output addressDataOut, byteEnablesOut, burstSizeOut,
    input  addressDataIn, endTransactionIn, dataValidIn, busErrorIn
  );

  modport slave (
    output cmdValidIn, cmdReadNWriteIn, cmdAddressIn, cmdWriteDataIn, cmdByteEnablesIn,
    input  cmdReadyOut, respValidOut, respReadDataOut, respErrorOut,
    input  requestOut,
    output grantIn,
    input  beginTransactionOut, endTransactionOut, readNWriteOut, dataValidOut, busyOut,
    input  addressDataOut, byteEnablesOut, burstSizeOut,
    output addressDataIn, endTransactionIn, dataValidIn, busErrorIn
  );
endinterface

// File: rtl/bus_timeout_counter.sv
// Counts consecutive cycles while i_run is high; o_expired flags the LIMIT-th such cycle. Cleared whenever i_run drops.
module bus_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  output logic o_expired
);

  localparam int              W    = $clog2(LIMIT) + 1;
  localparam logic [W-1:0]    LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset || !i_run) begin
      r_count <= '0;
    end else if (r_count != LAST) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_run && (r_count == LAST);

endmodule

// File: rtl/bus_single_initiator.sv
// Single-initiator bus master: one command at a time, arbitrate, drive begin/data/end phases, pulse one registered response.
// cmdReadyOut only in IDLE; BUS_TIMEOUT_EN adds a read-reply timeout of TIMEOUT_CYCLES cycles in WAIT_READ.
module bus_single_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                    clock,
  input logic                    reset,
  bus_single_initiator_if.master bif
);

  state_t      r_state, w_state_next;
  logic        r_rnw;
  logic [31:0] r_addr, r_wdata, r_rdata, w_rdata_next;
  logic [3:0]  r_be;
  logic        r_err, w_err_next;
  logic        w_accept, w_timeout;

  logic        w_cmd_ready, w_request, w_begin, w_data_vld, w_end, w_busy, w_rnw;
  logic        w_resp_vld, w_resp_err;
  logic [31:0] w_addr_data, w_resp_data;
  logic [3:0]  w_be;
  logic [7:0]  w_burst;

  logic        r_cmd_ready, r_request, r_begin, r_data_vld, r_end, r_busy, r_rnw_out;
  logic        r_resp_vld, r_resp_err;
  logic [31:0] r_addr_data, r_resp_data;
  logic [3:0]  r_be_out;
  logic [7:0]  r_burst;

`ifdef BUS_TIMEOUT_EN
  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_run     (r_state == ST_WAIT_READ),
    .o_expired (w_timeout)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  assign w_accept = (r_state == ST_IDLE) && bif.cmdValidIn;

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    w_rdata_next = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (bif.cmdValidIn) begin
          w_state_next = ST_REQUEST;
          w_err_next   = 1'b0;
          w_rdata_next = '0;
        end
      end
      ST_REQUEST: begin
        if (bif.grantIn) w_state_next = ST_BEGIN;
      end
      ST_BEGIN: begin
        if (bif.busErrorIn) begin
          w_err_next   = 1'b1;
          w_state_next = ST_ERR_END;
        end else begin
          w_state_next = r_rnw ? ST_WAIT_READ : ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (bif.busErrorIn) begin
          w_err_next   = 1'b1;
          w_state_next = ST_ERR_END;
        end else begin
          w_state_next = ST_WEND;
        end
      end
      ST_WEND: begin
        // The end strobe is already on the bus, so a late error is only reported.
        if (bif.busErrorIn) w_err_next = 1'b1;
        w_state_next = ST_RESPOND;
      end
      ST_WAIT_READ: begin
        if (bif.dataValidIn) w_rdata_next = bif.addressDataIn;
        if (bif.busErrorIn) begin
          w_err_next   = 1'b1;
          w_state_next = ST_ERR_END;
        end else if (bif.endTransactionIn) begin
          w_state_next = ST_RESPOND;
        end else if (w_timeout) begin
          w_err_next   = 1'b1;
          w_state_next = ST_ERR_END;
        end
      end
      ST_ERR_END:  w_state_next = ST_RESPOND;
      ST_RESPOND:  w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each strobe lines up with its state.
  always_comb begin
    w_cmd_ready = (w_state_next == ST_IDLE);
    w_request   = holds_bus(w_state_next);
    w_begin     = (w_state_next == ST_BEGIN);
    w_data_vld  = (w_state_next == ST_WDATA);
    w_end       = (w_state_next == ST_WEND) || (w_state_next == ST_ERR_END);
    w_busy      = w_state_next inside {ST_BEGIN, ST_WDATA, ST_WEND};
    w_rnw       = w_begin && r_rnw;
    w_addr_data = '0;
    if (w_begin)         w_addr_data = r_addr;
    else if (w_data_vld) w_addr_data = r_wdata;
    w_be        = w_begin ? r_be : '0;
    w_burst     = w_begin ? BURST_SIZE : '0;
    w_resp_vld  = (w_state_next == ST_RESPOND);
    w_resp_err  = w_resp_vld && w_err_next;
    w_resp_data = (w_resp_vld && r_rnw && !w_err_next) ? w_rdata_next : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rnw       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_cmd_ready <= 1'b1;
      r_request   <= 1'b0;
      r_begin     <= 1'b0;
      r_data_vld  <= 1'b0;
      r_end       <= 1'b0;
      r_busy      <= 1'b0;
      r_rnw_out   <= 1'b0;
      r_addr_data <= '0;
      r_be_out    <= '0;
      r_burst     <= '0;
      r_resp_vld  <= 1'b0;
      r_resp_err  <= 1'b0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_state_next;
      r_err   <= w_err_next;
      r_rdata <= w_rdata_next;
      if (w_accept) begin
        r_rnw   <= bif.cmdReadNWriteIn;
        r_addr  <= bif.cmdAddressIn;
        r_wdata <= bif.cmdWriteDataIn;
        r_be    <= bif.cmdByteEnablesIn;
      end
      r_cmd_ready <= w_cmd_ready;
      r_request   <= w_request;
      r_begin     <= w_begin;
      r_data_vld  <= w_data_vld;
      r_end       <= w_end;
      r_busy      <= w_busy;
      r_rnw_out   <= w_rnw;
      r_addr_data <= w_addr_data;
      r_be_out    <= w_be;
      r_burst     <= w_burst;
      r_resp_vld  <= w_resp_vld;
      r_resp_err  <= w_resp_err;
      r_resp_data <= w_resp_data;
    end
  end

  assign bif.cmdReadyOut         = r_cmd_ready;
  assign bif.requestOut          = r_request;
  assign bif.beginTransactionOut = r_begin;
  assign bif.dataValidOut        = r_data_vld;
  assign bif.endTransactionOut   = r_end;
  assign bif.busyOut             = r_busy;
  assign bif.readNWriteOut       = r_rnw_out;
  assign bif.addressDataOut      = r_addr_data;
  assign bif.byteEnablesOut      = r_be_out;
  assign bif.burstSizeOut        = r_burst;
  assign bif.respValidOut        = r_resp_vld;
  assign bif.respErrorOut        = r_resp_err;
  assign bif.respReadDataOut     = r_resp_data;

endmodule

// File: tb/tb_bus_single_initiator.sv
// Directed and randomized transactions against a cycle-timeline reference built from the protocol rules.
module tb_bus_single_initiator;

  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_single_initiator_if bif();

  bus_single_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bif   (bif)
  );

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {ready, request, begin, rnw, dataValid, endTransaction, respValid, respError}
  function automatic logic [7:0] strobes();
    return {bif.cmdReadyOut, bif.requestOut, bif.beginTransactionOut, bif.readNWriteOut,
            bif.dataValidOut, bif.endTransactionOut, bif.respValidOut, bif.respErrorOut};
  endfunction

  function automatic logic [43:0] bus_fields();
    return {bif.addressDataOut, bif.byteEnablesOut, bif.burstSizeOut};
  endfunction

  task automatic idle_inputs();
    bif.cmdValidIn       = 1'b0;
    bif.cmdReadNWriteIn  = 1'b0;
    bif.cmdAddressIn     = '0;
    bif.cmdWriteDataIn   = '0;
    bif.cmdByteEnablesIn = '0;
    bif.grantIn          = 1'b0;
    bif.addressDataIn    = '0;
    bif.endTransactionIn = 1'b0;
    bif.dataValidIn      = 1'b0;
    bif.busErrorIn       = 1'b0;
  endtask

  // Cycle c counts cycles after the accepting edge. err_at: write 1/2/3 = BEGIN/WDATA/WEND,
  // read = WAIT_READ cycle index. end_j = WAIT_READ cycle of endTransactionIn (0 = never).
  // rst_j > 0 applies reset in that WAIT_READ cycle instead of completing.
  task automatic run_txn(input bit rnw, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int gd, input int err_at, input int end_j,
                         input int beat_j, input logic [31:0] beat_val, input int rst_j,
                         input string tag);
    int b, dvc, endc, resp, term, horizon, j;
    bit is_err;
    logic [31:0] exp_data, ad_e, rd_e;
    logic [31:0] bv [64];
    bit          bon[64];
    logic [7:0]  exp_s;

    b = gd + 2; dvc = 0; endc = 0; resp = 0; term = 1000; is_err = 0; exp_data = '0;
    for (int k = 0; k < 64; k++) begin
      bv[k]  = $urandom;
      bon[k] = 1'b0;
    end
    if (rnw) begin
      if (beat_j > 0) begin
        bon[beat_j] = 1'b1;
        bv[beat_j]  = beat_val;
      end else begin
        for (int k = 1; k < 40; k++) bon[k] = 1'($urandom_range(0, 1));
      end
      if (end_j > 0) term = end_j;
      if (err_at > 0 && err_at <= term) begin term = err_at; is_err = 1; end
`ifdef BUS_TIMEOUT_EN
      if (TMO < term) begin term = TMO; is_err = 1; end
`endif
      if (is_err) begin
        endc = b + term + 1;
        resp = b + term + 2;
      end else if (term < 1000) begin
        resp = b + term + 1;
        for (int k = 1; k <= term; k++) if (bon[k]) exp_data = bv[k];
      end
    end else begin
      if (err_at == 1) begin
        endc = b + 1; resp = b + 2; is_err = 1;
      end else begin
        dvc = b + 1; endc = b + 2; resp = b + 3; is_err = (err_at >= 2);
      end
    end
    horizon = (rst_j > 0) ? b + rst_j : resp + 1;

    check({tag, " ready before accept"}, 64'(bif.cmdReadyOut), 64'(1));
    bif.cmdValidIn       = 1'b1;
    bif.cmdReadNWriteIn  = rnw;
    bif.cmdAddressIn     = addr;
    bif.cmdWriteDataIn   = wdata;
    bif.cmdByteEnablesIn = be;
    bif.grantIn          = (gd == 0);

    for (int c = 1; c <= horizon; c++) begin
      @(negedge clock);
      if (c == 1) begin
        bif.cmdValidIn       = 1'b0;
        bif.cmdAddressIn     = $urandom;
        bif.cmdWriteDataIn   = $urandom;
      end
      exp_s = {(resp > 0 && c > resp), (resp == 0 || c < resp), (c == b), (rnw && c == b),
               (c == dvc), (c == endc), (c == resp), (c == resp && is_err)};
      ad_e = (c == b) ? addr : ((c == dvc) ? wdata : 32'h0);
      rd_e = (c == resp) ? exp_data : 32'h0;
      check($sformatf("%s strobes c=%0d", tag, c), 64'(strobes()), 64'(exp_s));
      check($sformatf("%s bus c=%0d", tag, c), 64'(bus_fields()),
            64'({ad_e, (c == b) ? be : 4'h0, 8'h00}));
      check($sformatf("%s rdata c=%0d", tag, c), 64'(bif.respReadDataOut), 64'(rd_e));
      if (rnw && c > b && c - b <= term)
        check($sformatf("%s busy c=%0d", tag, c), 64'(bif.busyOut), 64'(0));

      j = c - b;
      bif.grantIn = (c > b) ? 1'($urandom_range(0, 1)) : (c >= gd + 1);
      if (rnw && j >= 1 && j <= term && j < 64) begin
        bif.dataValidIn      = bon[j];
        bif.addressDataIn    = bv[j];
        bif.endTransactionIn = (j == end_j);
        bif.busErrorIn       = (j == err_at);
      end else begin
        bif.dataValidIn      = 1'($urandom_range(0, 1));
        bif.endTransactionIn = 1'($urandom_range(0, 1));
        bif.addressDataIn    = $urandom;
        bif.busErrorIn       = (!rnw && err_at > 0 && c == b + err_at - 1);
      end

      if (rst_j > 0 && c == horizon) begin
        reset          = 1'b0;
        bif.cmdValidIn = 1'b1;
        @(negedge clock);
        check({tag, " reset strobes"}, 64'(strobes()), 64'(8'h80));
        check({tag, " reset bus"}, 64'(bus_fields()), 64'(0));
        check({tag, " reset busy/rdata"}, 64'({bif.busyOut, bif.respReadDataOut}), 64'(0));
        reset = 1'b1;
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          check($sformatf("%s after reset k=%0d", tag, k), 64'(strobes()), 64'(8'h80));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    bit          rnw;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    int          gd, err_at, end_j;

    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clock);
    check("reset strobes", 64'(strobes()), 64'(8'h80));
    check("reset bus", 64'(bus_fields()), 64'(0));
    check("reset busy/rdata", 64'({bif.busyOut, bif.respReadDataOut}), 64'(0));
    reset = 1'b1;

    run_txn(1'b0, 32'h5000_0004, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 32'h0, 0, "write");
    run_txn(1'b1, 32'h5000_0000, 32'h0, 4'hF, 0, 0, 4, 1, 32'hCAFE_0001, 0, "read");
    run_txn(1'b1, 32'h5000_0008, 32'h0, 4'h3, 0, 3, 0, 0, 32'h0, 0, "read_err");
    run_txn(1'b0, 32'h5000_0010, 32'hA5A5_0F0F, 4'h1, 10, 0, 0, 0, 32'h0, 0, "grant_wait");
    run_txn(1'b0, 32'h5000_0020, 32'h1111_2222, 4'hC, 0, 1, 0, 0, 32'h0, 0, "wr_err_begin");
    run_txn(1'b0, 32'h5000_0024, 32'h3333_4444, 4'h6, 2, 2, 0, 0, 32'h0, 0, "wr_err_wdata");
    run_txn(1'b0, 32'h5000_0028, 32'h5555_6666, 4'h9, 1, 3, 0, 0, 32'h0, 0, "wr_err_wend");
`ifdef BUS_TIMEOUT_EN
    run_txn(1'b1, 32'h5000_0030, 32'h0, 4'hF, 1, 0, 0, 0, 32'h0, 0, "timeout");
`endif
    run_txn(1'b1, 32'h5000_0040, 32'h0, 4'hF, 0, 0, 0, 0, 32'h0, 12, "reset_in_wait");

    for (int i = 0; i < 30; i++) begin
      rnw    = 1'($urandom_range(0, 1));
      addr   = $urandom;
      wdata  = $urandom;
      be     = 4'($urandom_range(0, 15));
      gd     = $urandom_range(0, 4);
      end_j  = $urandom_range(1, 8);
      err_at = 0;
      if ($urandom_range(0, 3) == 0) err_at = rnw ? $urandom_range(1, 9) : $urandom_range(1, 3);
      run_txn(rnw, addr, wdata, be, gd, err_at, end_j, 0, 32'h0, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
